id_ex_register: RTL

Pipeline register between the ID and EX stages of the five-stage MIPS core. It latches the register-file read data (A/B), the decoded control bits, register numbers, the sign-extended immediate and PC+4 for the EX stage. It also contains two pieces of ID-stage hazard logic:
- a write-back bypass that covers the register file's same-edge write/read gap;
- a load-use hazard detector that stalls PC and IF/ID and inserts one bubble.

---
 rtl/id_ex_register_if.sv | 58 +++++
 rtl/id_ex_register.sv | 106 ++++++++++
 2 files changed

// File: rtl/id_ex_register_if.sv
// ID/EX boundary bundle: ID-side operands, decoded controls and write-back
// bypass inputs, plus the latched EX-side fields and hazard outputs.
interface id_ex_register_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_a;
  logic [31:0]      id_b;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [15:0]      id_imm;
  logic [31:0]      id_pc4;
  logic             id_regwrite;
  logic             id_memtoreg;
  logic             id_memread;
  logic             id_memwrite;
  logic             id_alusrc;
  logic             id_regdst;
  logic [1:0]       id_aluop;
  logic             flush;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             stall;
  logic [31:0]      ex_a;
  logic [31:0]      ex_b;
  logic [31:0]      ex_imm;
  logic [31:0]      ex_pc4;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memtoreg;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             ex_alusrc;
  logic             ex_regdst;
  logic [1:0]       ex_aluop;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output id_a, id_b, id_rs, id_rt, id_rd, id_imm, id_pc4,
    output id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_regdst, id_aluop,
    output flush, wb_regwrite, wb_rd, wb_data,
    input  stall, ex_a, ex_b, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
    input  ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_regdst, ex_aluop,
    input  bubble_count
  );

  modport slave (
    input  id_a, id_b, id_rs, id_rt, id_rd, id_imm, id_pc4,
    input  id_regwrite, id_memtoreg, id_memread, id_memwrite, id_alusrc, id_regdst, id_aluop,
    input  flush, wb_regwrite, wb_rd, wb_data,
    output stall, ex_a, ex_b, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
    output ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc, ex_regdst, ex_aluop,
    output bubble_count
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with write-back bypass on the operands and
// load-use hazard detection that inserts a single bubble per stall.
module id_ex_register #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  id_ex_register_if.slave bus
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic        alusrc;
    logic        regdst;
    logic [1:0]  aluop;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [31:0] a_sel, b_sel;
  logic             stall_w;

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ID side: bypass and hazard detection
  always_comb begin
    a_sel = bus.id_a;
    b_sel = bus.id_b;
    if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs)) a_sel = bus.wb_data;
    if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rt)) b_sel = bus.wb_data;
  end

  assign stall_w = ex_q.memread & (ex_q.rt != 5'd0) &
                   ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));

  always_comb begin
    ex_d          = '0;
    cnt_d         = cnt_q;
    if (bus.flush) begin
      ex_d        = '0;
    end else if (stall_w) begin
      ex_d        = '0;
      cnt_d       = sat_inc(cnt_q);
    end else begin
      ex_d.a        = a_sel;
      ex_d.b        = b_sel;
      ex_d.imm      = sext16(bus.id_imm);
      ex_d.pc4      = bus.id_pc4;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.rd       = bus.id_rd;
      ex_d.regwrite = bus.id_regwrite;
      ex_d.memtoreg = bus.id_memtoreg;
      ex_d.memread  = bus.id_memread;
      ex_d.memwrite = bus.id_memwrite;
      ex_d.alusrc   = bus.id_alusrc;
      ex_d.regdst   = bus.id_regdst;
      ex_d.aluop    = bus.id_aluop;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall        = stall_w;
  assign bus.ex_a         = ex_q.a;
  assign bus.ex_b         = ex_q.b;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_pc4       = ex_q.pc4;
  assign bus.ex_rs        = ex_q.rs;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_memtoreg  = ex_q.memtoreg;
  assign bus.ex_memread   = ex_q.memread;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_regdst    = ex_q.regdst;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.bubble_count = cnt_q;

endmodule
